// File: rtl/piso_tx_controller_pkg.sv
// Shared OPR codes and controller state encoding for the serial transmit controller.
package piso_tx_pkg;

  typedef logic [1:0] opr_t;

  localparam opr_t OPR_HOLD = 2'd0;
  localparam opr_t OPR_LOAD = 2'd1;
  localparam opr_t OPR_SHL  = 2'd2;
  localparam opr_t OPR_CLR  = 2'd3;

  // PARITY only becomes reachable when PISO_TX_PARITY_EN is defined
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/piso_tx_controller_if.sv
// Parallel word handshake between a producer and the serial transmit controller.
interface piso_tx_controller_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/piso_tx_controller_shreg_opr.sv
// Parallel-load, left-shift register driven by a 2-bit OPR command; exposes its MSB.
module shreg_opr
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  opr_t             opr,
  input  logic [WIDTH-1:0] d,
  input  logic             l,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      case (opr)
        OPR_LOAD: q <= d;
        OPR_SHL:  q <= {q[WIDTH-2:0], l};
        OPR_CLR:  q <= '0;
        default:  q <= q;
      endcase
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/piso_tx_controller.sv
// Start/data/stop serial transmitter sequencing a shreg_opr register MSB-first.
// Optional even-parity bit before the stop bit when PISO_TX_PARITY_EN is defined.
module piso_tx_controller
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  piso_tx_controller_if.slave  bus,
  input  logic                 abort,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           opr_mon
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  opr_t          opr;
  logic          msb;
  logic          bit_end;
  logic          last_bit;

  assign bit_end  = (div_cnt == DW'(DIV - 1));
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (bus.valid_in) state_nxt = START;
        START:  if (bit_end) state_nxt = DATA;
`ifdef PISO_TX_PARITY_EN
        DATA:   if (bit_end && last_bit) state_nxt = PARITY;
`else
        DATA:   if (bit_end && last_bit) state_nxt = STOP;
`endif
        PARITY: if (bit_end) state_nxt = STOP;
        STOP:   if (bit_end) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    opr  = OPR_HOLD;
    done = 1'b0;
    if (abort) begin
      opr = OPR_CLR;
    end else begin
      case (state)
        IDLE:    if (bus.valid_in) opr = OPR_LOAD;
        DATA:    if (bit_end) opr = OPR_SHL;
        STOP:    done = bit_end;
        default: opr = OPR_HOLD;
      endcase
    end
  end

  // Divider runs only inside a frame; with DIV=1 it never leaves 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (abort || state == IDLE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + BW'(1);
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic par;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          par <= 1'b0;
    else if (abort)                      par <= 1'b0;
    else if (state == IDLE && bus.valid_in) par <= ^bus.data_in;
  end
`endif

  always_comb begin
    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = msb;
`ifdef PISO_TX_PARITY_EN
      PARITY:  tx_out = par;
`endif
      default: tx_out = 1'b1;
    endcase
  end

  shreg_opr #(.WIDTH(WIDTH)) u_shreg (
    .clock (clock),
    .reset (reset),
    .opr   (opr),
    .d     (bus.data_in),
    .l     (1'b0),
    .msb   (msb)
  );

  assign bus.ready_out = (state == IDLE) && !abort;
  assign busy          = !bus.ready_out;
  assign opr_mon       = opr;

endmodule

// File: tb/tb_piso_tx_controller.sv
// Directed bench for piso_tx_controller: three instances (W4/D2, W8/D1, W4/D1).
module tb_piso_tx_controller;

`ifdef PISO_TX_PARITY_EN
  localparam int NB4 = 7;
  localparam int NB8 = 11;
  localparam logic [NB4-1:0] F_B  = 7'b0_1011_1_1;
  localparam logic [NB4-1:0] F_A  = 7'b0_1010_0_1;
  localparam logic [NB4-1:0] F_5  = 7'b0_0101_0_1;
  localparam logic [NB4-1:0] F_7  = 7'b0_0111_1_1;
  localparam logic [NB8-1:0] F_81 = 11'b0_10000001_0_1;
`else
  localparam int NB4 = 6;
  localparam int NB8 = 10;
  localparam logic [NB4-1:0] F_B  = 6'b0_1011_1;
  localparam logic [NB4-1:0] F_A  = 6'b0_1010_1;
  localparam logic [NB4-1:0] F_5  = 6'b0_0101_1;
  localparam logic [NB4-1:0] F_7  = 6'b0_0111_1;
  localparam logic [NB8-1:0] F_81 = 10'b0_10000001_1;
`endif

  logic clock, reset;
  int   errors = 0;
  int   checks = 0;

  piso_tx_controller_if #(.WIDTH(4)) a_bus ();
  piso_tx_controller_if #(.WIDTH(8)) b_bus ();
  piso_tx_controller_if #(.WIDTH(4)) c_bus ();
  logic       a_abort, a_tx, a_busy, a_done;
  logic       b_abort, b_tx, b_busy, b_done;
  logic       c_abort, c_tx, c_busy, c_done;
  logic [1:0] a_opr, b_opr, c_opr;

  piso_tx_controller #(.WIDTH(4), .DIV(2)) u_a (
    .clock(clock), .reset(reset), .bus(a_bus), .abort(a_abort),
    .tx_out(a_tx), .busy(a_busy), .done(a_done), .opr_mon(a_opr));
  piso_tx_controller #(.WIDTH(8), .DIV(1)) u_b (
    .clock(clock), .reset(reset), .bus(b_bus), .abort(b_abort),
    .tx_out(b_tx), .busy(b_busy), .done(b_done), .opr_mon(b_opr));
  piso_tx_controller #(.WIDTH(4), .DIV(1)) u_c (
    .clock(clock), .reset(reset), .bus(c_bus), .abort(c_abort),
    .tx_out(c_tx), .busy(c_busy), .done(c_done), .opr_mon(c_opr));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every cycle of one W4/D2 frame; called in the cycle right after accept.
  task automatic watch_a(input logic [NB4-1:0] bits, input string tag);
    for (int i = 0; i < NB4 * 2; i++) begin
      @(negedge clock);
      check({tag, ".tx"},   32'(a_tx),   32'(bits[NB4-1-i/2]));
      check({tag, ".done"}, 32'(a_done), 32'(i == NB4 * 2 - 1));
      check({tag, ".busy"}, 32'(a_busy), 32'd1);
      check({tag, ".opr"},  32'(a_opr),  (i >= 2 && i < 10 && i % 2 == 1) ? 32'd2 : 32'd0);
    end
  endtask

  task automatic send_a(input logic [3:0] w, input logic [NB4-1:0] bits, input string tag);
    @(posedge clock); #1;
    a_bus.data_in = w; a_bus.valid_in = 1'b1;
    @(negedge clock);
    check({tag, ".rdy"},  32'(a_bus.ready_out), 32'd1);
    check({tag, ".load"}, 32'(a_opr), 32'd1);
    @(posedge clock); #1;
    a_bus.valid_in = 1'b0;
    watch_a(bits, tag);
    @(negedge clock);
    check({tag, ".after"}, {28'd0, a_bus.ready_out, a_tx, a_busy, a_done}, 32'b1100);
  endtask

  initial begin
    reset = 1'b0;
    a_abort = 1'b0; b_abort = 1'b0; c_abort = 1'b0;
    a_bus.data_in = '0; a_bus.valid_in = 1'b0;
    b_bus.data_in = '0; b_bus.valid_in = 1'b0;
    c_bus.data_in = '0; c_bus.valid_in = 1'b0;
    #1;
    check("rst_a", {26'd0, a_bus.ready_out, a_tx, a_busy, a_done, a_opr}, 32'b110000);
    check("rst_b", {26'd0, b_bus.ready_out, b_tx, b_busy, b_done, b_opr}, 32'b110000);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // single frame, 1011
    send_a(4'b1011, F_B, "f1011");

    // abort in IDLE blocks accept and issues clear
    @(posedge clock); #1;
    a_abort = 1'b1; a_bus.valid_in = 1'b1; a_bus.data_in = 4'hF;
    @(negedge clock);
    check("idle_abort.rdy", 32'(a_bus.ready_out), 32'd0);
    check("idle_abort.opr", 32'(a_opr), 32'd3);
    @(posedge clock); #1;
    a_abort = 1'b0; a_bus.valid_in = 1'b0;
    @(negedge clock);
    check("idle_abort.after", {29'd0, a_bus.ready_out, a_tx, a_busy}, 32'b110);

    // back-to-back A then 5 with valid held high
    @(posedge clock); #1;
    a_bus.data_in = 4'hA; a_bus.valid_in = 1'b1;
    @(posedge clock); #1;
    a_bus.data_in = 4'h5;
    watch_a(F_A, "b2b_A");
    @(negedge clock);
    check("b2b.gap", {28'd0, a_bus.ready_out, a_tx, a_done, 1'b0}, 32'b1100);
    check("b2b.load", 32'(a_opr), 32'd1);
    @(posedge clock); #1;
    a_bus.valid_in = 1'b0;
    watch_a(F_5, "b2b_5");
    @(negedge clock);
    check("b2b.end", {29'd0, a_bus.ready_out, a_done, a_busy}, 32'b100);

    // abort during the second data bit
    @(posedge clock); #1;
    a_bus.data_in = 4'hA; a_bus.valid_in = 1'b1;
    @(posedge clock); #1;
    a_bus.valid_in = 1'b0;
    repeat (4) @(negedge clock);
    check("abort.bit0", 32'(a_tx), 32'd1);
    @(posedge clock); #1;
    a_abort = 1'b1;
    @(negedge clock);
    check("abort.opr", 32'(a_opr), 32'd3);
    check("abort.cyc", {29'd0, a_bus.ready_out, a_busy, a_done}, 32'b010);
    @(posedge clock); #1;
    a_abort = 1'b0;
    @(negedge clock);
    check("abort.after", {26'd0, a_bus.ready_out, a_tx, a_busy, a_done, a_opr}, 32'b110000);
    send_a(4'h5, F_5, "post_abort");

    // async reset mid-DATA
    @(posedge clock); #1;
    a_bus.data_in = 4'b1011; a_bus.valid_in = 1'b1;
    @(posedge clock); #1;
    a_bus.valid_in = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst", {28'd0, a_bus.ready_out, a_tx, a_busy, a_done}, 32'b1100);
    @(posedge clock); #1 reset = 1'b1;
    send_a(4'b1011, F_B, "post_rst");

    // W8/D1, 0x81, valid toggling mid-frame
    @(posedge clock); #1;
    b_bus.data_in = 8'h81; b_bus.valid_in = 1'b1;
    @(posedge clock); #1;
    b_bus.valid_in = 1'b0; b_bus.data_in = 8'hFF;
    for (int i = 0; i < NB8; i++) begin
      @(negedge clock);
      check("b81.tx",   32'(b_tx),   32'(F_81[NB8-1-i]));
      check("b81.done", 32'(b_done), 32'(i == NB8 - 1));
      @(posedge clock); #1;
      b_bus.valid_in = (i < NB8 - 2) ? ~b_bus.valid_in : 1'b0;
    end
    @(negedge clock);
    check("b81.after", {29'd0, b_bus.ready_out, b_tx, b_busy}, 32'b110);

    // W4/D1, 0111
    @(posedge clock); #1;
    c_bus.data_in = 4'b0111; c_bus.valid_in = 1'b1;
    @(posedge clock); #1;
    c_bus.valid_in = 1'b0;
    for (int i = 0; i < NB4; i++) begin
      @(negedge clock);
      check("c7.tx",   32'(c_tx),   32'(F_7[NB4-1-i]));
      check("c7.done", 32'(c_done), 32'(i == NB4 - 1));
    end
    @(negedge clock);
    check("c7.after", {29'd0, c_bus.ready_out, c_tx, c_busy}, 32'b110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_tx_controller.md
Name: piso_tx_controller

Overview:
Serial transmit controller that sequences a parallel-load, left-shift register through OPR commands: hold, load, shift-left, clear. Accepts a parallel word over a valid/ready handshake and drives it out MSB-first on one line. The frame is a start bit, WIDTH data bits and a stop bit, with each bit held DIV clocks. Sits between a parallel producer (FSM or counter) and a serial pin or downstream serial consumer.

Parameters:
WIDTH, 4, data word width in bits (>=2)
DIV, 4, clock cycles per serial bit (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
data_in  input  WIDTH  parallel word to transmit
valid_in  input  1  producer has a word on data_in
ready_out  output  1  controller can accept a word this cycle
abort  input  1  synchronous cancel of the current frame
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at the end of a completed frame
opr_mon  output  2  OPR code issued to the shift register this cycle (debug)

Behaviour:
- Reset (reset==0, async): state IDLE, shift register 0, bit counter 0, divider counter 0. Outputs: tx_out=1, busy=0, done=0, ready_out=1, opr_mon=0.
- Reset mid-frame: frame is dropped immediately. No done pulse.
- ready_out = (state==IDLE) && !abort. busy = !ready_out outside reset.
- tx_out, busy and ready_out decode from registers only. No combinational path from data_in or valid_in.
- OPR encoding: 0 hold, 1 load, 2 shift-left (serial-in l tied 0), 3 clear.
- Accept: rising edge with valid_in && ready_out → issue OPR=1 (register <= data_in), go to START. valid_in while not ready is ignored; no word is queued.
- States and transitions:
  - IDLE: OPR=0, tx_out=1. On accept → START.
  - START: tx_out=0 for DIV cycles, OPR=0. → DATA.
  - DATA: tx_out = register MSB. On the last cycle of each bit period issue OPR=2 and increment the bit counter. After WIDTH bits → STOP.
  - STOP: tx_out=1 for DIV cycles. done=1 on the final STOP cycle. → IDLE.
- Timing: accept at edge k → tx_out=0 on cycles k+1..k+DIV. Frame occupies (WIDTH+2)*DIV cycles. ready_out returns the cycle after done.
- Minimum gap between frames is 1 cycle. Back-to-back accept on the first IDLE cycle is legal.
- DIV=1: every cycle is a bit-period end. The divider counter stays at 0.
- Abort: takes priority over everything except reset. In any non-IDLE state, the next edge → IDLE with OPR=3 (register cleared), tx_out=1, no done. Abort in IDLE issues OPR=3 and blocks accept that cycle.
- Counters:
  - Divider counter is $clog2(DIV) bits (min 1) and wraps to 0 at DIV-1.
  - Bit counter is $clog2(WIDTH+1) bits and clears on entry to START.

Optional Feature:
Macro PISO_TX_PARITY_EN.
- Defined:
  - Even-parity bit (XOR of data_in) is captured at accept.
  - A PARITY state sits between DATA and STOP and drives tx_out=parity for DIV cycles.
  - Frame length is (WIDTH+3)*DIV.
  - Abort clears the captured parity.
- Undefined: no parity register, no PARITY state, frame as above.

Decomposition:
- Package piso_tx_pkg:
  - OPR constants OPR_HOLD=2'd0, OPR_LOAD=2'd1, OPR_SHL=2'd2, OPR_CLR=2'd3.
  - State typedef IDLE/START/DATA/PARITY/STOP. PARITY is present in the typedef unconditionally and unreachable without the macro.
- One sub-module, shreg_opr:
  - Parameterised WIDTH, holding the register.
  - Inputs: OPR, serial-in l, clock, reset.
  - Output: MSB.
  - The controller instantiates it with l=0.

Test Plan:
- WIDTH=4, DIV=2, send 4'b1011 → tx_out 0,0,1,1,0,0,1,1,1,1,1,1 on cycles k+1..k+12. done on k+12. ready_out=1 on k+13.
- Two words 4'hA then 4'h5 with valid_in held high → second accept on the first IDLE cycle after done. tx_out bits 1010 then 0101. Exactly two done pulses.
- abort asserted during the 2nd data bit → next cycle tx_out=1, opr_mon=3, state IDLE, no done. A fresh word then transmits correctly.
- Reset pulsed low mid-DATA → tx_out=1, busy=0, done=0 immediately. After release ready_out=1, and the next frame is correct.
- DIV=1, WIDTH=8, send 8'h81 → tx_out 0,1,0,0,0,0,0,0,1,1 on consecutive cycles. valid_in toggled during the frame is ignored.
- PISO_TX_PARITY_EN, WIDTH=4, DIV=1, send 4'b0111 → tx_out 0,0,1,1,1,1,1. done on the stop cycle (frame length 7).
